// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, qualifies a synchronised lock,
// then releases downstream domain resets one channel at a time with retry/fault handling.
module pll_lock_supervisor #(
    parameter int unsigned N_CH                = 2,
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 25000,
    parameter int unsigned STAGGER_CYCLES      = 4,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                                 clk_25MHz,
    input  logic                                 rst_n,
    input  logic                                 pll_locked,
    input  logic                                 reinit,
    output logic                                 pll_rst,
    output logic [N_CH-1:0]                      sys_rst_n,
    output logic                                 ready,
    output logic                                 fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_cnt,
    output logic [7:0]                           lock_loss_cnt
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned RW         = $clog2(MAX_RETRIES + 1);
    localparam int unsigned REL_CYCLES = (N_CH - 1) * STAGGER_CYCLES;
    localparam int unsigned T_MAX      = max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                              max2(LOCK_TIMEOUT_CYCLES, REL_CYCLES));
    localparam int unsigned TW         = $clog2(T_MAX + 1);
    localparam int unsigned REL_LAST   = (REL_CYCLES > 0) ? REL_CYCLES - 1 : 0;

    localparam logic [TW-1:0] T_PLLRST_LAST  = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] T_TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] T_RELEASE_LAST = TW'(REL_LAST);
    localparam logic [TW-1:0] T_SAT         = TW'(T_MAX);

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAIT,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [RW-1:0]   retry_nxt;
    logic [7:0]      loss_nxt;
    logic            pll_rst_nxt, ready_nxt, fault_nxt;
    logic [N_CH-1:0] sys_nxt;
    logic            lock_meta, lock_s;

    // Two-flop synchroniser for the asynchronous lock indicator
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Next state, counters and next-cycle outputs
    always_comb begin
        state_nxt   = state;
        retry_nxt   = retry_cnt;
        loss_nxt    = lock_loss_cnt;
        timer_nxt   = timer;
        pll_rst_nxt = 1'b0;
        ready_nxt   = 1'b0;
        fault_nxt   = 1'b0;
        sys_nxt     = '0;

        if (reinit) begin
            state_nxt = S_PLLRST;
            retry_nxt = '0;
        end else begin
            unique case (state)
                S_PLLRST: begin
                    if (timer == T_PLLRST_LAST) state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                    end else if (timer == T_TIMEOUT_LAST) begin
                        if (retry_cnt == RW'(MAX_RETRIES)) begin
                            state_nxt = S_FAULT;
                        end else begin
                            retry_nxt = retry_cnt + RW'(1);
                            state_nxt = S_PLLRST;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = S_WAIT;
                    end else if (timer == T_STABLE_LAST) begin
                        state_nxt = (N_CH == 1) ? S_RUN : S_RELEASE;
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (!lock_s) begin
                        loss_nxt  = (lock_loss_cnt == 8'hFF) ? 8'hFF : lock_loss_cnt + 8'd1;
                        state_nxt = S_PLLRST;
                    end else if (state == S_RELEASE && timer == T_RELEASE_LAST) begin
                        state_nxt = S_RUN;
                    end
                end
                S_FAULT: state_nxt = S_FAULT;
                default: state_nxt = S_PLLRST;
            endcase
        end

        if (state_nxt == S_RUN && state != S_RUN) retry_nxt = '0;

        // Timer restarts on any state change or reinit and saturates otherwise
        if (reinit || state_nxt != state) begin
            timer_nxt = '0;
        end else if (timer != T_SAT) begin
            timer_nxt = timer + TW'(1);
        end

        pll_rst_nxt = (state_nxt == S_PLLRST) || (state_nxt == S_FAULT);
        ready_nxt   = (state_nxt == S_RUN);
        fault_nxt   = (state_nxt == S_FAULT);

        // Last channel is released on RUN entry so ready rises with it
        if (state_nxt == S_RUN) begin
            sys_nxt = '1;
        end else if (state_nxt == S_RELEASE) begin
            for (int unsigned i = 0; i + 1 < N_CH; i++) begin
                if (i * STAGGER_CYCLES <= 32'(timer_nxt)) sys_nxt = sys_nxt | (N_CH'(1) << i);
            end
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_PLLRST;
            timer         <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= '0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            pll_rst       <= pll_rst_nxt;
            sys_rst_n     <= sys_nxt;
            ready         <= ready_nxt;
            fault         <= fault_nxt;
        end
    end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of downstream reset channels, 1..8.
REQ-002 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_rst held high per PLL reset pulse, >=1.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronised-lock cycles required before release, >=1.
REQ-004 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 25000: max cycles in WAIT before retry, >=1.
REQ-005 SHALL have parameter STAGGER_CYCLES, default 4: cycles between successive channel releases, >=1.
REQ-006 SHALL have parameter MAX_RETRIES, default 3: consecutive failed lock attempts tolerated before FAULT, >=1.
REQ-007 SHALL have port clk_25MHz  input  1  free-running 25 MHz reference clock; sole clock.
REQ-008 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port pll_locked  input  1  raw PLL LOCK, asynchronous to clk_25MHz.
REQ-010 SHALL have port reinit  input  1  single-cycle request to restart the PLL.
REQ-011 SHALL have port pll_rst  output  1  active-high reset to PLL RST pin.
REQ-012 SHALL have port sys_rst_n  output  N_CH  per-channel active-low domain resets.
REQ-013 SHALL have port ready  output  1  high only in RUN.
REQ-014 SHALL have port fault  output  1  high only in FAULT.
REQ-015 SHALL have port retry_cnt  output  clog2(MAX_RETRIES+1)  failed attempts since last RUN/reinit.
REQ-016 SHALL have port lock_loss_cnt  output  8  lock losses seen in RELEASE/RUN, saturating at 255.

Function
REQ-017 pll_locked SHALL pass through a 2-flop synchroniser (lock_s); all decisions use lock_s only.
REQ-018 All outputs SHALL be registered; FSM states: PLLRST, WAIT, STABLE, RELEASE, RUN, FAULT.
REQ-019 PLLRST: pll_rst=1, sys_rst_n=all 0; after exactly PLL_RST_CYCLES cycles -> WAIT.
REQ-020 WAIT: pll_rst=0; lock_s=1 -> STABLE; LOCK_TIMEOUT_CYCLES elapsed without lock_s -> failure (REQ-024).
REQ-021 STABLE: counts consecutive lock_s=1; reaching LOCK_STABLE_CYCLES -> RELEASE; any lock_s=0 -> WAIT with timeout counter restarted.
REQ-022 RELEASE: sys_rst_n[i] SHALL rise i*STAGGER_CYCLES cycles after RELEASE entry (bit 0 in first RELEASE cycle); after bit N_CH-1 rises -> RUN; released bits stay high.
REQ-023 RUN: ready=1, retry_cnt cleared on entry; remains while lock_s=1.
REQ-024 Failure (WAIT timeout): if retry_cnt==MAX_RETRIES -> FAULT, else retry_cnt+1 and -> PLLRST.
REQ-025 Lock loss (lock_s=0 in RELEASE or RUN): lock_loss_cnt+1 (saturating), all sys_rst_n low and ready low in the next cycle, -> PLLRST; retry_cnt not incremented.
REQ-026 FAULT: pll_rst=1, sys_rst_n=all 0, fault=1; exits only on reinit or rst_n.
REQ-027 reinit=1 in any state SHALL force -> PLLRST with retry_cnt=0; reinit has priority over lock loss, timeout and stable completion in the same cycle.
REQ-028 Counters SHALL be sized clog2(parameter+1) and never wrap; timer counters clear on every state change.
REQ-029 lock_s glitches in PLLRST SHALL be ignored.

Reset
REQ-030 rst_n low SHALL asynchronously force: state PLLRST, pll_rst=1, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, synchroniser flops 0, all timers 0.
REQ-031 On rst_n release, PLLRST timing SHALL start at the first clk_25MHz rising edge; reset mid-sequence SHALL abandon any partial release.

Verification (bench params N_CH=3, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=100, STAGGER_CYCLES=2, MAX_RETRIES=2)
REQ-032 Normal bring-up: rst_n rise, pll_locked=1 from cycle 10 -> pll_rst high cycles 0-3; sys_rst_n 001, 011, 111 at 2-cycle spacing after 8 stable cycles; ready with bit 2; retry_cnt=0.
REQ-033 No lock: pll_locked held 0 -> three 4-cycle pll_rst pulses spaced 100 WAIT cycles apart, retry_cnt 0->1->2, then fault=1, pll_rst=1 steady.
REQ-034 Stability glitch: pll_locked drops 1 cycle during STABLE -> WAIT re-entered, release delayed by full 8 further stable cycles; no retry_cnt change.
REQ-035 Lock loss in RUN: pll_locked low 1 cycle -> sys_rst_n=000, ready=0, lock_loss_cnt=1, pll_rst pulse, normal re-release.
REQ-036 reinit from FAULT coincident with lock_s change -> PLLRST, fault=0, retry_cnt=0, full bring-up completes.
REQ-037 rst_n asserted mid-RELEASE (sys_rst_n=011) -> all outputs at reset values immediately, without waiting for a clock edge.
